// File: rtl/game_screen_ctrl.sv
// ---------------------------------------------------------------------------
// game_screen_ctrl
//
// Screen sequencer for the OLED game. It sits in front of the title,
// controls-help and play-field renderers:
//   * turns the OLED driver's linear pixel_index into registered (x,y)
//     coordinates that feed every renderer,
//   * debounces the five push-buttons,
//   * runs the menu state machine that chooses the active screen,
//   * muxes the active renderer's colour into a registered oled_data.
// A screen change is only committed when pixel 0 of a frame is sampled,
// so one frame is always drawn entirely from one screen.
//
// Ports
//   clk          in   1   OLED pixel clock, the only clock
//   reset        in   1   synchronous, active-high reset
//   pixel_index  in  13   pixel address from the OLED driver
//   btnC..btnD   in   1   raw asynchronous push-buttons
//   game_over    in   1   one-cycle pulse from the game logic
//   title_data   in  16   title renderer colour for the current (x,y)
//   ctrl_data    in  16   controls-help renderer colour
//   play_data    in  16   play-field renderer colour
//   x            out  7   registered column
//   y            out  6   registered row
//   oled_data    out 16   registered colour to the OLED driver
//   screen_id    out  2   0 TITLE, 1 CONTROLS, 2 PLAY, 3 OVER
//   game_start   out  1   one-cycle pulse when PLAY is committed
//   play_btn     out  5   {C,U,L,R,D} press pulses, only while in PLAY
// ---------------------------------------------------------------------------

`default_nettype none

// ---------------------------------------------------------------------------
// button_debounce
//
// One push-button: 2-FF synchroniser, then a counter that must see the
// synchronised level disagree with the accepted level for DEBOUNCE_CYCLES
// consecutive cycles before the accepted level follows it.
//
// Ports
//   clk     in  1   clock
//   reset   in  1   synchronous, active-high reset
//   raw     in  1   asynchronous button input
//   press   out 1   single-cycle pulse on the accepted 0->1 edge
// ---------------------------------------------------------------------------
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int CNT_W           = 17
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic             stable;
    logic             stable_d;
    logic [CNT_W-1:0] cnt;

    // Synchroniser plus stability counter. Any cycle where the synchronised
    // level agrees with the accepted level restarts the count, so a glitch
    // shorter than DEBOUNCE_CYCLES never reaches the accepted level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a   <= 1'b0;
            sync_b   <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
        end else begin
            sync_a   <= raw;
            sync_b   <= sync_a;
            stable_d <= stable;
            if (sync_b == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync_b;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Rising edge of the accepted level; holding the button gives no repeat.
    assign press = stable & ~stable_d;

endmodule

// ---------------------------------------------------------------------------
// Top level
// ---------------------------------------------------------------------------
module game_screen_ctrl #(
    parameter int          WIDTH           = 96,
    parameter int          HEIGHT          = 64,
    parameter int          DEBOUNCE_CYCLES = 65536,
    parameter int          CNT_W           = 17,
    parameter logic [15:0] BG_COLOUR       = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [12:0] pixel_index,
    input  logic        btnC,
    input  logic        btnU,
    input  logic        btnL,
    input  logic        btnR,
    input  logic        btnD,
    input  logic        game_over,
    input  logic [15:0] title_data,
    input  logic [15:0] ctrl_data,
    input  logic [15:0] play_data,
    output logic [6:0]  x,
    output logic [5:0]  y,
    output logic [15:0] oled_data,
    output logic [1:0]  screen_id,
    output logic        game_start,
    output logic [4:0]  play_btn
);

    localparam int NUM_PIXELS = WIDTH * HEIGHT;

    // Bit positions inside the {C,U,L,R,D} press vector.
    localparam int B_C = 4;
    localparam int B_U = 3;
    localparam int B_L = 2;

    typedef enum logic [1:0] {
        S_TITLE    = 2'd0,
        S_CONTROLS = 2'd1,
        S_PLAY     = 2'd2,
        S_OVER     = 2'd3
    } screen_t;

    // -----------------------------------------------------------------------
    // Button debouncers
    // -----------------------------------------------------------------------
    logic [4:0] raw_btns;
    logic [4:0] press;

    assign raw_btns = {btnC, btnU, btnL, btnR, btnD};

    for (genvar g = 0; g < 5; g++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk  (clk),
            .reset(reset),
            .raw  (raw_btns[g]),
            .press(press[g])
        );
    end

    // -----------------------------------------------------------------------
    // Menu state machine
    // -----------------------------------------------------------------------
    screen_t screen_q;
    screen_t screen_d;
    screen_t pending_state_q;
    screen_t pending_state_d;
    screen_t req_state;
    logic    pending_q;
    logic    pending_d;
    logic    req_valid;
    logic    commit;
    logic    game_start_d;

    // Request decode. game_over only means something in PLAY, and buttons
    // never request anything there. Outside PLAY only the highest-priority
    // press (C > U > L > R > D) is looked at; R and D have no transitions.
    always_comb begin
        req_valid = 1'b0;
        req_state = screen_q;
        if (screen_q == S_PLAY) begin
            if (game_over) begin
                req_valid = 1'b1;
                req_state = S_OVER;
            end
        end else if (press[B_C]) begin
            req_valid = 1'b1;
            case (screen_q)
                S_TITLE:    req_state = S_CONTROLS;
                S_CONTROLS: req_state = S_PLAY;
                default:    req_state = S_TITLE;
            endcase
        end else if (press[B_U]) begin
            if (screen_q == S_CONTROLS) begin
                req_valid = 1'b1;
                req_state = S_PLAY;
            end
        end else if (press[B_L]) begin
            if (screen_q == S_CONTROLS) begin
                req_valid = 1'b1;
                req_state = S_TITLE;
            end
        end
    end

    // Pending request and frame-aligned commit. A request only latches while
    // nothing is pending, so the first one wins. Because commit looks at the
    // registered pending flag, a request arriving on pixel 0 waits a frame.
    always_comb begin
        screen_d        = screen_q;
        pending_d       = pending_q;
        pending_state_d = pending_state_q;
        game_start_d    = 1'b0;
        commit          = (pixel_index == 13'd0) && pending_q;
        if (commit) begin
            screen_d     = pending_state_q;
            pending_d    = 1'b0;
            game_start_d = (pending_state_q == S_PLAY);
        end else if (!pending_q && req_valid) begin
            pending_d       = 1'b1;
            pending_state_d = req_state;
        end
    end

    // Menu state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            screen_q        <= S_TITLE;
            pending_q       <= 1'b0;
            pending_state_q <= S_TITLE;
            game_start      <= 1'b0;
        end else begin
            screen_q        <= screen_d;
            pending_q       <= pending_d;
            pending_state_q <= pending_state_d;
            game_start      <= game_start_d;
        end
    end

    assign screen_id = screen_q;

    // Button presses reach the game logic only while the play field is shown.
    always_ff @(posedge clk) begin
        if (reset) begin
            play_btn <= '0;
        end else begin
            play_btn <= (screen_q == S_PLAY) ? press : 5'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Coordinate and colour pipeline
    // -----------------------------------------------------------------------
    logic       pix_in_range;
    logic [6:0] pix_col;
    logic [5:0] pix_row;
    logic       s1_in_range;
    screen_t    s1_screen;

    assign pix_in_range = (pixel_index < 13'(NUM_PIXELS));
    assign pix_col      = 7'(pixel_index % 13'(WIDTH));
    assign pix_row      = 6'(pixel_index / 13'(WIDTH));

    // Stage 1: coordinates for the renderers. The screen carried along is
    // screen_d, so pixel 0 of a committing frame already uses the new screen
    // and the whole frame comes from a single renderer.
    always_ff @(posedge clk) begin
        if (reset) begin
            x           <= '0;
            y           <= '0;
            s1_in_range <= 1'b0;
            s1_screen   <= S_TITLE;
        end else begin
            x           <= pix_in_range ? pix_col : 7'd0;
            y           <= pix_in_range ? pix_row : 6'd0;
            s1_in_range <= pix_in_range;
            s1_screen   <= screen_d;
        end
    end

    // Stage 2: the renderers answer combinationally for the stage-1 (x,y),
    // so their colour is captured one cycle after the coordinates. The game
    // over screen reuses the play field with its colours inverted.
    always_ff @(posedge clk) begin
        if (reset) begin
            oled_data <= BG_COLOUR;
        end else if (!s1_in_range) begin
            oled_data <= BG_COLOUR;
        end else begin
            case (s1_screen)
                S_TITLE:    oled_data <= title_data;
                S_CONTROLS: oled_data <= ctrl_data;
                S_PLAY:     oled_data <= play_data;
                default:    oled_data <= ~play_data;
            endcase
        end
    end

endmodule

`default_nettype wire
